// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receiver for 8-data/parity/stop frames
module uart_receiver #(
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_VALID
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    logic [2:0]  baud_q;
    logic [13:0] tick_cnt;
    logic [3:0]  tick_idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        vote7_q;
    logic        vote8_q;
    logic        mismatch_q;
    logic        stop_q;
    logic        stop_done_q;
    logic        armed_q;

    logic sample_tick;
    logic at_tick9;
    logic bit_end;
    logic maj;
    logic start_detect;
    logic out_load;

    // Last count of the tick divider (divisor minus one) for each baud code.
    function automatic logic [13:0] div_last(input logic [2:0] code);
        logic [13:0] d;
        case (code)
            3'b000:  d = 14'd10416;
            3'b001:  d = 14'd2603;
            3'b010:  d = 14'd650;
            3'b011:  d = 14'd325;
            3'b100:  d = 14'd162;
            3'b101:  d = 14'd80;
            3'b110:  d = 14'd53;
            default: d = 14'd26;
        endcase
        return d;
    endfunction

    assign rxd_s        = sync_q[SYNC_STAGES-1];
    assign sample_tick  = (state != IDLE) && (tick_cnt == div_last(baud_q));
    assign at_tick9     = sample_tick && (tick_idx == 4'd9);
    assign bit_end      = sample_tick && (tick_idx == 4'd15);
    // Majority of the samples taken at ticks 7 and 8 plus the live sample at tick 9.
    assign maj          = (vote7_q & vote8_q) | (vote7_q & rxd_s) | (vote8_q & rxd_s);
    // A low line only starts a frame once it has been seen high since the last break.
    assign start_detect = (state == IDLE) && Rx_EN && armed_q && !rxd_s;

    // Bring the asynchronous serial line into the clock domain; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; the output load strobe fires one clock after the stop sample.
    always_comb begin
        state_n  = state;
        out_load = 1'b0;
        if ((state != IDLE) && !Rx_EN) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_detect) begin
                        state_n = START;
                    end
                end
                START: begin
                    if (at_tick9 && maj) begin
                        state_n = IDLE;
                    end else if (bit_end) begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (bit_end && (bit_cnt == 3'd7)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (stop_done_q) begin
                        state_n  = IDLE;
                        out_load = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Tick divider and tick-within-bit index; held at zero while idle so the
    // first tick of a frame is phase-aligned to the detected start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tick_idx <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            tick_idx <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
            tick_idx <= tick_idx + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + 14'd1;
        end
    end

    // Baud code is captured at start detect and ignored for the rest of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q <= '0;
        end else if (start_detect) begin
            baud_q <= baud_select;
        end
    end

    // Mid-bit voting samples at ticks 7 and 8.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote7_q <= 1'b0;
            vote8_q <= 1'b0;
        end else if (sample_tick) begin
            if (tick_idx == 4'd7) begin
                vote7_q <= rxd_s;
            end
            if (tick_idx == 4'd8) begin
                vote8_q <= rxd_s;
            end
        end
    end

    // Data shift register (LSB first) and data bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
        end else if (state == DATA) begin
            if (at_tick9) begin
                shift_q <= {maj, shift_q[7:1]};
            end
            if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Parity comparison and stop-bit capture; stop_done_q marks the output update cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q  <= 1'b0;
            stop_q      <= 1'b0;
            stop_done_q <= 1'b0;
        end else begin
            if ((state == PARITY) && at_tick9) begin
                mismatch_q <= maj ^ (^shift_q) ^ PARITY_ODD;
            end
            if (state != STOP) begin
                stop_done_q <= 1'b0;
            end else if (at_tick9) begin
                stop_q      <= maj;
                stop_done_q <= 1'b1;
            end
        end
    end

    // Break guard: a zero stop bit disarms start detection until the line returns high.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b1;
        end else if (out_load && !stop_q) begin
            armed_q <= 1'b0;
        end else if (rxd_s) begin
            armed_q <= 1'b1;
        end
    end

    // Result registers: flags cleared at start detect, everything loaded once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            Rx_DATA   <= '0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_VALID  <= 1'b0;
        end else if (start_detect) begin
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_VALID  <= 1'b0;
        end else if (out_load) begin
            Rx_DATA   <= shift_q;
            Rx_PERROR <= mismatch_q;
            Rx_FERROR <= !stop_q;
            Rx_VALID  <= !mismatch_q && stop_q;
        end
    end

endmodule
